// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 binary-to-BCD converter.
// One add-3 stage per BCD digit; one iteration per clock, W iterations per
// conversion. Optional two's-complement input gives a sign + magnitude result.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  bin is valid
//   in_ready  block can accept bin this cycle
//   bin       binary operand, W bits
//   out_valid result is valid and held until out_ready
//   out_ready consumer takes the result
//   bcd       packed BCD, digit k at bcd[4k+3:4k], digit 0 is the ones digit
//   neg       result is negative (always 0 when SIGNED=0)
//   ndig      number of significant digits, 1..D (leading-zero blanking)
module bin_to_bcd_seq #(
  parameter int unsigned W      = 16,
  parameter int unsigned SIGNED = 0,
  localparam int unsigned D     = (W * 301 + 999) / 1000,
  localparam int unsigned NW    = $clog2(D + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*D-1:0]  bcd,
  output logic            neg,
  output logic [NW-1:0]   ndig
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [4*D-1:0]  work_q, work_d;
  logic            neg_work_q, neg_work_d;
  logic [4*D-1:0]  bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic [NW-1:0]   ndig_q, ndig_d;

  logic [4*D-1:0]  adj;
  logic [4*D+W-1:0] shifted;
  logic [4*D-1:0]  next_digits;
  logic [NW-1:0]   next_ndig;
  logic            accept;
  logic            neg_in;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ndig      = ndig_q;

  // Datapath for one iteration: per-digit add-3 correction, then shift
  // {digits, mag} left by one. Digits never carry into each other.
  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < D; k++) begin
      adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ? work_q[4*k +: 4] + 4'd3
                                                 : work_q[4*k +: 4];
    end
    shifted     = {adj, mag_q} << 1;
    next_digits = shifted[4*D+W-1:W];
    next_ndig   = NW'(1);
    for (int unsigned k = 0; k < D; k++) begin
      if (next_digits[4*k +: 4] != 4'd0) begin
        next_ndig = NW'(k + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    work_d     = work_q;
    neg_work_d = neg_work_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ndig_d     = ndig_q;

    accept = in_valid & in_ready;
    neg_in = (SIGNED != 0) && bin[W-1];

    case (state_q)
      SHIFT: begin
        work_d = next_digits;
        mag_d  = shifted[W-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = next_digits;
          neg_d   = neg_work_q;
          ndig_d  = next_ndig;
        end
      end
      IDLE, DONE: begin
        // DONE with out_ready and in_valid hands off and captures on one edge.
        if (accept) begin
          mag_d      = neg_in ? -bin : bin;
          neg_work_d = neg_in;
          work_d     = '0;
          cnt_d      = CW'(W);
          state_d    = SHIFT;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      neg_work_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ndig_q     <= NW'(1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      neg_work_q <= neg_work_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ndig_q     <= ndig_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a W=16 unsigned instance and a W=8 signed instance
// share clock and reset. A decimal-arithmetic model with a cycle-level
// handshake model is checked against both instances on every falling edge;
// directed tests add hand-computed expectations for values and latency.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  iv;
  logic [1:0]  orr;
  logic [31:0] bin_a [2];
  logic [1:0]  ir;
  logic [1:0]  ov;
  logic [1:0]  neg_o;
  logic [19:0] bcd16;
  logic [11:0] bcd8;
  logic [2:0]  nd16;
  logic [1:0]  nd8;
  logic [39:0] bcd_o [2];
  logic [7:0]  nd_o  [2];

  bin_to_bcd_seq #(.W(16), .SIGNED(0)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .bin       (bin_a[0][15:0]),
    .out_valid (ov[0]),
    .out_ready (orr[0]),
    .bcd       (bcd16),
    .neg       (neg_o[0]),
    .ndig      (nd16)
  );

  bin_to_bcd_seq #(.W(8), .SIGNED(1)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .bin       (bin_a[1][7:0]),
    .out_valid (ov[1]),
    .out_ready (orr[1]),
    .bcd       (bcd8),
    .neg       (neg_o[1]),
    .ndig      (nd8)
  );

  assign bcd_o[0] = {20'b0, bcd16};
  assign bcd_o[1] = {28'b0, bcd8};
  assign nd_o[0]  = {5'b0, nd16};
  assign nd_o[1]  = {6'b0, nd8};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int get_w(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic bit get_s(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  // Decimal reference: interpret the operand as an integer, take |value|,
  // and peel decimal digits off with / and %.
  function automatic void conv(input int i, input logic [31:0] b,
                               output logic [39:0] bcd, output logic ng,
                               output logic [7:0] nd);
    longint unsigned raw, v, full;
    int w;
    w    = get_w(i);
    full = 64'd1 << w;
    raw  = {32'b0, b} & (full - 64'd1);
    ng   = get_s(i) && b[w-1];
    v    = ng ? full - raw : raw;
    bcd  = '0;
    nd   = 8'd1;
    for (int k = 0; k < 10; k++) begin
      bcd[4*k +: 4] = 4'(v % 10);
      if ((v % 10) != 0) nd = 8'(k + 1);
      v = v / 10;
    end
  endfunction

  logic [39:0] c_bcd [2];
  logic        c_neg [2];
  logic [7:0]  c_nd  [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      c_bcd[i] = '0;
      c_neg[i] = 1'b0;
      c_nd[i]  = 8'd1;
      conv(i, bin_a[i], c_bcd[i], c_neg[i], c_nd[i]);
    end
  end

  // Handshake model: phase 0 idle, 1 converting (m_left cycles to go),
  // 2 result presented.
  int          m_phase [2];
  int          m_left  [2];
  logic [39:0] m_pbcd  [2];
  logic        m_pneg  [2];
  logic [7:0]  m_pnd   [2];
  logic [39:0] m_bcd   [2];
  logic        m_neg   [2];
  logic [7:0]  m_nd    [2];

  function automatic bit m_ready(input int i);
    return (m_phase[i] == 0) || ((m_phase[i] == 2) && orr[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0;
        m_left[i]  <= 0;
        m_pbcd[i]  <= '0;
        m_pneg[i]  <= 1'b0;
        m_pnd[i]   <= 8'd1;
        m_bcd[i]   <= '0;
        m_neg[i]   <= 1'b0;
        m_nd[i]    <= 8'd1;
      end else if (m_phase[i] == 1) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_phase[i] <= 2;
          m_bcd[i]   <= m_pbcd[i];
          m_neg[i]   <= m_pneg[i];
          m_nd[i]    <= m_pnd[i];
        end
      end else if (m_ready(i)) begin
        if (iv[i]) begin
          m_phase[i] <= 1;
          m_left[i]  <= get_w(i);
          m_pbcd[i]  <= c_bcd[i];
          m_pneg[i]  <= c_neg[i];
          m_pnd[i]   <= c_nd[i];
        end else if (m_phase[i] == 2) begin
          m_phase[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit bad_digit;
      bad_digit = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (bcd_o[i][4*k +: 4] > 4'd9) bad_digit = 1'b1;
      end
      chk($sformatf("d%0d_in_ready", i), ir[i], m_ready(i));
      chk($sformatf("d%0d_out_valid", i), ov[i], m_phase[i] == 2);
      chk($sformatf("d%0d_bcd", i), bcd_o[i], m_bcd[i]);
      chk($sformatf("d%0d_neg", i), neg_o[i], m_neg[i]);
      chk($sformatf("d%0d_ndig", i), nd_o[i], m_nd[i]);
      chk($sformatf("d%0d_digit_range", i), bad_digit, 0);
    end
  end

  int          mq_cyc [$];
  logic [39:0] mq_bcd [$];

  always @(negedge clk) begin
    if (rst_n && ov[0]) begin
      mq_cyc.push_back(cyc);
      mq_bcd.push_back(bcd_o[0]);
    end
  end

  task automatic send(input int i, input logic [31:0] v, input bit keep);
    int c;
    bit acc;
    c = 0;
    acc = 1'b0;
    bin_a[i] = v;
    iv[i] = 1'b1;
    while (!acc && c < 200) begin
      acc = m_ready(i);
      @(posedge clk);
      #1;
      c++;
    end
    chk($sformatf("d%0d_accept_%0d", i, v), acc, 1);
    if (!keep) iv[i] = 1'b0;
  endtask

  task automatic wait_result(input int i, input string nm, input logic [39:0] eb,
                             input bit en, input int end_, input int elat);
    int c;
    c = 0;
    while (!ov[i] && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({nm, "_valid"}, ov[i], 1);
    chk({nm, "_latency"}, c, elat);
    chk({nm, "_bcd"}, bcd_o[i], eb);
    chk({nm, "_neg"}, neg_o[i], en);
    chk({nm, "_ndig"}, nd_o[i], end_);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    iv       = 2'b00;
    orr      = 2'b11;
    bin_a[0] = '0;
    bin_a[1] = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_bcd", bcd_o[0], 0);
    chk("rst_ndig", nd_o[0], 1);
    chk("rst_in_ready", ir[0], 1);
    chk("rst_neg8", neg_o[1], 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(0, 65535, 0);
    wait_result(0, "u65535", 40'h65535, 0, 5, 16);
    send(0, 0, 0);
    wait_result(0, "u0", 40'h00000, 0, 1, 16);
    send(0, 1000, 0);
    wait_result(0, "u1000", 40'h01000, 0, 4, 16);

    send(1, 32'h80, 0);
    wait_result(1, "s80", 40'h128, 1, 3, 8);
    send(1, 32'hFF, 0);
    wait_result(1, "sFF", 40'h001, 1, 1, 8);
    send(1, 32'h7F, 0);
    wait_result(1, "s7F", 40'h127, 0, 3, 8);

    orr[0] = 1'b0;
    send(0, 1234, 0);
    wait_result(0, "bp", 40'h01234, 0, 4, 16);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_bcd", bcd_o[0], 40'h01234);
      chk("bp_hold_valid", ov[0], 1);
      chk("bp_hold_in_ready", ir[0], 0);
    end
    orr[0] = 1'b1;
    send(0, 9, 0);
    chk("bp_handoff_valid_drop", ov[0], 0);
    wait_result(0, "bp_next", 40'h00009, 0, 1, 16);
    @(posedge clk);
    #1;

    mq_cyc.delete();
    mq_bcd.delete();
    send(0, 100, 1);
    send(0, 200, 1);
    send(0, 300, 0);
    for (int c = 0; c < 100 && mq_cyc.size() < 3; c++) begin
      @(posedge clk);
      #1;
    end
    chk("stream_count", mq_cyc.size(), 3);
    if (mq_cyc.size() >= 3) begin
      chk("stream_r0", mq_bcd[0], 40'h00100);
      chk("stream_r1", mq_bcd[1], 40'h00200);
      chk("stream_r2", mq_bcd[2], 40'h00300);
      chk("stream_gap01", mq_cyc[1] - mq_cyc[0], 17);
      chk("stream_gap12", mq_cyc[2] - mq_cyc[1], 17);
    end
    @(posedge clk);
    #1;

    send(0, 4321, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_shift_valid", ov[0], 0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", ov[0], 0);
    chk("abort_bcd", bcd_o[0], 0);
    chk("abort_ndig", nd_o[0], 1);
    chk("abort_in_ready", ir[0], 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 42, 0);
    wait_result(0, "post_rst", 40'h00042, 0, 2, 16);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Multi-cycle, parametrised binary-to-BCD converter (iterative shift-add-3) with valid/ready handshakes on input and output.
- Replaces the single-cycle unrolled converter in the score path. Area is one add-3 stage per digit instead of a W-deep array.
- Adds signed-input mode and a significant-digit count, which the score display uses for leading-zero blanking.
- Sits between the score accumulator (producer) and the 7-segment/HUD digit renderer (consumer).

Parameters:
- W, 16, input binary width; legal range 1..32.
- SIGNED, 0, 0 = input is unsigned; 1 = input is two's complement and the output is sign + magnitude.
- D, (W*301+999)/1000, localparam, number of BCD digits; equals ceil(W*log10 2). W=16 gives D=5; W=8 gives D=3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bin is valid.
- in_ready  out  1  block can accept bin this cycle.
- bin  in  W  binary operand.
- out_valid  out  1  result is valid and held.
- out_ready  in  1  consumer takes the result.
- bcd  out  4*D  packed BCD; digit k is bcd[4k+3:4k], and digit 0 is the ones digit.
- neg  out  1  result is negative; always 0 when SIGNED=0.
- ndig  out  clog2(D+1)  number of significant digits, 1..D.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; bcd=0; neg=0; ndig=1; iteration counter=0.
  - Shift and work registers cleared.
  - in_ready follows state (1 in IDLE), but no capture occurs while rst_n is low.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Input acceptance:
  - An input is accepted on any edge with in_valid & in_ready.
  - Capture: mag = (SIGNED & bin[W-1]) ? -bin : bin, computed mod 2^W. Since -2^(W-1) yields magnitude 2^(W-1), the result fits in W bits unsigned.
  - neg_next is latched; work digits are cleared; counter=W; state goes to SHIFT.
- SHIFT, one iteration per cycle:
  - Every digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {digits, mag} shifts left by 1.
  - Counter decrements. On the edge completing iteration W, the result registers are loaded, out_valid=1, and state goes to DONE.
- Latency: out_valid rises exactly W cycles after the accepting edge.
- DONE:
  - bcd, neg and ndig are held stable while out_valid=1 & out_ready=0. Backpressure is unlimited.
  - On out_ready=1: if in_valid is also 1, the new input is captured on the same edge and state goes to SHIFT (out_valid drops); otherwise state goes to IDLE and out_valid=0.
  - Back-to-back throughput: one result per W+1 cycles.
- bcd, neg and ndig are registered and change only on the edge that enters DONE.
- in_valid is ignored during SHIFT, and bin may change freely after acceptance.
- ndig is the index of the most-significant nonzero digit + 1. A zero result gives ndig=1.
- neg is never set for a zero magnitude.
- Every digit value is always in 0..9. A digit > 9 is a bug and the bench asserts on it.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately and returns everything to reset values. The partial result is never presented.
- W=1 edge case: D=1, one iteration, and latency is 1 cycle.

Test Plan:
- W=16, SIGNED=0: bin=65535, in_valid pulse, out_ready=1 -> out_valid rises 16 cycles after accept; bcd=20'h65535, neg=0, ndig=5.
- W=16: bin=0 -> bcd=20'h00000, ndig=1, neg=0. Then bin=1000 -> bcd=20'h01000, ndig=4.
- W=8, SIGNED=1: bin=8'h80 -> neg=1, bcd=12'h128, ndig=3. bin=8'hFF -> neg=1, bcd=12'h001, ndig=1. bin=8'h7F -> neg=0, bcd=12'h127.
- Backpressure (W=16): bin=1234, hold out_ready=0 for 10 cycles after out_valid -> bcd=20'h01234 stable, in_ready=0. Assert out_ready with in_valid=1, bin=9 -> new accept on the same edge; next result bcd=20'h00009 exactly 16 cycles later.
- Back-to-back streaming: in_valid=1 and out_ready=1 continuously with 100, 200, 300 -> results spaced 17 cycles apart with correct bcd, and no values dropped or duplicated.
- Reset mid-SHIFT (assert rst_n=0 at iteration 7 of bin=4321) -> out_valid=0, bcd=0, ndig=1 immediately. After release, a new bin=42 converts to bcd=20'h00042 with normal latency.
